// File: rtl/life_grid_engine.sv
`default_nettype none
// ============================================================================
// Module   : life_grid_engine
// Purpose  : Game-of-Life array engine. Holds a COLS x ROWS grid and advances
//            it by one generation per accepted step request. One row is
//            evaluated per clock into a shadow buffer, and the whole shadow is
//            committed to the grid in a single cycle.
// Ports    : qzt_clk    - system clock (rising edge)
//            rst_n      - asynchronous active-low reset
//            step       - request one generation
//            load_en    - write load_data into row load_row (idle only)
//            load_row   - row index for load and readout
//            load_data  - row data, bit c = column c, 1 = alive
//            rd_data    - registered copy of committed row load_row
//            busy       - generation in progress
//            done       - one-cycle pulse after commit
//            gen_count  - committed generation count (wraps)
//            extinct    - committed grid is all dead
//            stable     - last commit left the grid unchanged
//            overrun    - sticky, step arrived while busy
// Revision : 1.0 - initial release
// ============================================================================
module life_grid_engine #(
  parameter int         COLS         = 8,
  parameter int         ROWS         = 8,
  parameter int         WRAP         = 1,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
  parameter int         GEN_W        = 16
) (
  input  logic                     qzt_clk,
  input  logic                     rst_n,
  input  logic                     step,
  input  logic                     load_en,
  input  logic [$clog2(ROWS)-1:0]  load_row,
  input  logic [COLS-1:0]          load_data,
  output logic [COLS-1:0]          rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [GEN_W-1:0]         gen_count,
  output logic                     extinct,
  output logic                     stable,
  output logic                     overrun
);

  localparam int            RW         = $clog2(ROWS);
  localparam logic [RW-1:0] c_LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_rst_meta;
  logic                        r_rst_sync;
  logic [ROWS-1:0][COLS-1:0]   r_grid;
  logic [ROWS-1:0][COLS-1:0]   r_shadow;
  logic [RW-1:0]               r_row;
  logic [COLS-1:0]             r_rd_data;
  logic                        r_done;
  logic [GEN_W-1:0]            r_gen;
  logic                        r_extinct;
  logic                        r_stable;
  logic                        r_overrun;
  logic                        w_load_ok;
  logic [COLS-1:0]             w_up;
  logic [COLS-1:0]             w_mid;
  logic [COLS-1:0]             w_dn;
  logic [COLS-1:0]             w_next;

  // Reset asserts asynchronously but releases only after two clean edges so
  // every state flop leaves reset in the same cycle.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  // Row indices at or above ROWS are not backed by storage.
  assign w_load_ok = ({1'b0, load_row} < (RW + 1)'(ROWS));

  // Neighbour rows for the row under evaluation; edge rows either wrap or
  // see a dead row beyond the boundary.
  assign w_mid = r_grid[r_row];
  assign w_up  = (r_row == '0)
                 ? ((WRAP != 0) ? r_grid[ROWS-1] : '0)
                 : r_grid[r_row - RW'(1)];
  assign w_dn  = (r_row == c_LAST_ROW)
                 ? ((WRAP != 0) ? r_grid[0] : '0)
                 : r_grid[r_row + RW'(1)];

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int c_CL    = (c == 0) ? COLS - 1 : c - 1;
    localparam int c_CR    = (c == COLS - 1) ? 0 : c + 1;
    localparam bit c_HAS_L = (c != 0) || (WRAP != 0);
    localparam bit c_HAS_R = (c != COLS - 1) || (WRAP != 0);
    logic [3:0] w_cnt;

    assign w_cnt = 4'(w_up[c]) + 4'(w_dn[c])
                 + (c_HAS_L ? (4'(w_up[c_CL]) + 4'(w_mid[c_CL]) + 4'(w_dn[c_CL])) : 4'd0)
                 + (c_HAS_R ? (4'(w_up[c_CR]) + 4'(w_mid[c_CR]) + 4'(w_dn[c_CR])) : 4'd0);

    assign w_next[c] = w_mid[c] ? SURVIVE_MASK[w_cnt] : BIRTH_MASK[w_cnt];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!load_en && step) w_state_nxt = S_CALC;
      S_CALC:   if (r_row == c_LAST_ROW) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge qzt_clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge qzt_clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_grid    <= '0;
      r_shadow  <= '0;
      r_row     <= '0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
      r_gen     <= '0;
      r_extinct <= 1'b1;
      r_stable  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_rd_data <= w_load_ok ? r_grid[load_row] : '0;
      case (r_state)
        S_IDLE: begin
          // A load wins over a same-cycle step; that step is simply dropped.
          if (load_en) begin
            if (w_load_ok) r_grid[load_row] <= load_data;
            r_overrun <= 1'b0;
          end else if (step) begin
            r_row <= '0;
          end
        end
        S_CALC: begin
          r_shadow[r_row] <= w_next;
          r_row           <= r_row + RW'(1);
          if (step) r_overrun <= 1'b1;
        end
        S_COMMIT: begin
          r_grid    <= r_shadow;
          r_gen     <= r_gen + GEN_W'(1);
          r_stable  <= (r_shadow == r_grid);
          r_extinct <= (r_shadow == '0);
          r_done    <= 1'b1;
          if (step) r_overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_data   = r_rd_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign gen_count = r_gen;
  assign extinct   = r_extinct;
  assign stable    = r_stable;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_life_grid_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_life_grid_engine
// Purpose  : Self-checking bench. Two engines run in lockstep on shared
//            stimulus: A is 5x5 dead-edge, B is 8x8 toroidal. Each is tracked
//            by a cell-by-cell Life model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_grid_engine;

  typedef logic [7:0][7:0] grid_t;

  localparam logic [8:0] BIRTH = 9'b000001000;
  localparam logic [8:0] SURV  = 9'b000001100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step;
  logic        load_en;
  logic [2:0]  load_row;
  logic [7:0]  load_data;

  logic [4:0]  rd_a;
  logic        busy_a, done_a, ext_a, stab_a, ovr_a;
  logic [15:0] gen_a;
  logic [7:0]  rd_b;
  logic        busy_b, done_b, ext_b, stab_b, ovr_b;
  logic [15:0] gen_b;

  int    n_cmp = 0;
  int    n_bad = 0;
  grid_t m_grid [2];
  int    m_gen  [2];
  bit    m_stab [2];
  bit    m_ext  [2];
  bit    m_ovr  [2];
  int    d_rows [2] = '{5, 8};
  int    d_cols [2] = '{5, 8};
  int    d_wrap [2] = '{0, 1};

  always #5 clk = ~clk;

  life_grid_engine #(.COLS(5), .ROWS(5), .WRAP(0)) u_dut_a (
    .qzt_clk(clk), .rst_n(rst_n), .step(step), .load_en(load_en),
    .load_row(load_row), .load_data(load_data[4:0]), .rd_data(rd_a),
    .busy(busy_a), .done(done_a), .gen_count(gen_a), .extinct(ext_a),
    .stable(stab_a), .overrun(ovr_a)
  );

  life_grid_engine #(.COLS(8), .ROWS(8), .WRAP(1)) u_dut_b (
    .qzt_clk(clk), .rst_n(rst_n), .step(step), .load_en(load_en),
    .load_row(load_row), .load_data(load_data), .rd_data(rd_b),
    .busy(busy_b), .done(done_b), .gen_count(gen_b), .extinct(ext_b),
    .stable(stab_b), .overrun(ovr_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic grid_t life_next(input grid_t g, input int rows, input int cols, input int wrap);
    grid_t nx;
    int    n, rr, cc;
    nx = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (wrap != 0) begin
              rr = (rr + rows) % rows;
              cc = (cc + cols) % cols;
            end
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < rows && cc >= 0 && cc < cols)
              n += int'(g[rr][cc]);
          end
        end
        nx[r][c] = g[r][c] ? SURV[n] : BIRTH[n];
      end
    end
    return nx;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_grid[d] = '0;
      m_gen[d]  = 0;
      m_stab[d] = 1'b0;
      m_ext[d]  = 1'b1;
      m_ovr[d]  = 1'b0;
    end
  endtask

  task automatic check_status(input string tag);
    check_val({tag, ".genA"},  32'(gen_a), 32'(m_gen[0] % 65536));
    check_val({tag, ".genB"},  32'(gen_b), 32'(m_gen[1] % 65536));
    check_val({tag, ".stabA"}, 32'(stab_a), 32'(m_stab[0]));
    check_val({tag, ".stabB"}, 32'(stab_b), 32'(m_stab[1]));
    check_val({tag, ".extA"},  32'(ext_a), 32'(m_ext[0]));
    check_val({tag, ".extB"},  32'(ext_b), 32'(m_ext[1]));
    check_val({tag, ".ovrA"},  32'(ovr_a), 32'(m_ovr[0]));
    check_val({tag, ".ovrB"},  32'(ovr_b), 32'(m_ovr[1]));
  endtask

  task automatic check_grid(input string tag);
    for (int r = 0; r < 8; r++) begin
      load_row = 3'(r);
      tick();
      check_val($sformatf("%s.rdA%0d", tag, r), 32'(rd_a), 32'(m_grid[0][r]));
      check_val($sformatf("%s.rdB%0d", tag, r), 32'(rd_b), 32'(m_grid[1][r]));
    end
  endtask

  task automatic model_load(input int row, input logic [7:0] data);
    for (int d = 0; d < 2; d++) begin
      if (row < d_rows[d]) m_grid[d][row] = data & 8'((1 << d_cols[d]) - 1);
      m_ovr[d] = 1'b0;
    end
  endtask

  task automatic do_load(input int row, input logic [7:0] data);
    load_en   = 1'b1;
    load_row  = 3'(row);
    load_data = data;
    tick();
    load_en   = 1'b0;
    model_load(row, data);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    model_reset();
  endtask

  // inj_kind: 0 = none, 1 = extra step while busy, 2 = load while busy.
  // inj_cyc is counted in edges after the edge that accepted the step.
  task automatic run_gen(input int inj_kind, input int inj_cyc);
    int    lat_a, lat_b, cnt_a;
    grid_t nw;
    step = 1'b1;
    tick();
    step = 1'b0;
    check_val("gen.busyA", 32'(busy_a), 32'd1);
    check_val("gen.busyB", 32'(busy_b), 32'd1);
    for (int d = 0; d < 2; d++) begin
      nw        = life_next(m_grid[d], d_rows[d], d_cols[d], d_wrap[d]);
      m_stab[d] = (nw == m_grid[d]);
      m_ext[d]  = (nw == '0);
      m_grid[d] = nw;
      m_gen[d]++;
      if (inj_kind == 1) m_ovr[d] = 1'b1;
    end
    lat_a = 0;
    lat_b = 0;
    cnt_a = 0;
    for (int k = 1; k <= 16 && lat_b == 0; k++) begin
      if (k == inj_cyc && inj_kind == 1) step = 1'b1;
      if (k == inj_cyc && inj_kind == 2) begin
        load_en   = 1'b1;
        load_row  = 3'($urandom_range(0, 4));
        load_data = 8'($urandom);
      end
      tick();
      step    = 1'b0;
      load_en = 1'b0;
      if (done_a) cnt_a++;
      if (done_a && lat_a == 0) lat_a = k;
      if (done_b && lat_b == 0) lat_b = k;
    end
    check_val("gen.latA", 32'(lat_a), 32'd6);
    check_val("gen.latB", 32'(lat_b), 32'd9);
    check_val("gen.pulseA", 32'(cnt_a), 32'd1);
    tick();
    check_val("gen.doneB_low", 32'(done_b), 32'd0);
    check_val("gen.busyB_low", 32'(busy_b), 32'd0);
    check_status("gen");
  endtask

  grid_t pat;

  initial begin
    rst_n     = 1'b0;
    step      = 1'b0;
    load_en   = 1'b0;
    load_row  = '0;
    load_data = '0;
    model_reset();
    repeat (3) tick();
    check_val("rst.busyA", 32'(busy_a), 32'd0);
    check_val("rst.busyB", 32'(busy_b), 32'd0);
    check_val("rst.doneA", 32'(done_a), 32'd0);
    check_status("rst");
    rst_n = 1'b1;
    repeat (3) tick();
    check_grid("rst");

    // Blinker
    do_load(2, 8'b00001110);
    run_gen(0, 0);
    for (int r = 0; r < 5; r++) begin
      load_row = 3'(r);
      tick();
      check_val($sformatf("blink1.rowA%0d", r), 32'(rd_a), (r >= 1 && r <= 3) ? 32'h04 : 32'h0);
    end
    check_val("blink1.gen", 32'(gen_a), 32'd1);
    check_grid("blink1");
    run_gen(0, 0);
    load_row = 3'd2;
    tick();
    check_val("blink2.row2", 32'(rd_a), 32'h0E);
    check_val("blink2.gen", 32'(gen_a), 32'd2);
    check_val("blink2.stable", 32'(stab_a), 32'd0);
    check_grid("blink2");

    // Glider on the torus returns to its start after 32 generations
    do_reset();
    pat    = '0;
    pat[0] = 8'b00000010;
    pat[1] = 8'b00000100;
    pat[2] = 8'b00000111;
    for (int r = 0; r < 3; r++) do_load(r, pat[r]);
    repeat (32) run_gen(0, 0);
    for (int r = 0; r < 8; r++) begin
      load_row = 3'(r);
      tick();
      check_val($sformatf("glider.rowB%0d", r), 32'(rd_b), 32'(pat[r]));
    end
    check_val("glider.gen", 32'(gen_b), 32'd32);
    check_val("glider.ext", 32'(ext_b), 32'd0);
    check_grid("glider");

    // Block still life, then a lone cell dies out
    do_reset();
    do_load(1, 8'b00000110);
    do_load(2, 8'b00000110);
    run_gen(0, 0);
    check_val("block.stabA", 32'(stab_a), 32'd1);
    check_val("block.stabB", 32'(stab_b), 32'd1);
    check_grid("block");
    do_load(1, 8'b00000000);
    do_load(2, 8'b00000100);
    run_gen(0, 0);
    check_val("lone.extA", 32'(ext_a), 32'd1);
    check_val("lone.extB", 32'(ext_b), 32'd1);

    // Overrun is sticky until the next idle load
    do_load(3, 8'($urandom));
    run_gen(1, 3);
    check_val("ovr.setA", 32'(ovr_a), 32'd1);
    check_val("ovr.setB", 32'(ovr_b), 32'd1);
    do_load(0, 8'($urandom));
    check_val("ovr.clrA", 32'(ovr_a), 32'd0);
    check_val("ovr.clrB", 32'(ovr_b), 32'd0);

    // Load beats a simultaneous step
    load_en   = 1'b1;
    step      = 1'b1;
    load_row  = 3'd4;
    load_data = 8'($urandom);
    tick();
    load_en = 1'b0;
    step    = 1'b0;
    model_load(4, load_data);
    check_val("simul.busyA", 32'(busy_a), 32'd0);
    check_val("simul.busyB", 32'(busy_b), 32'd0);
    tick();
    tick();
    check_val("simul.busyB2", 32'(busy_b), 32'd0);
    check_status("simul");
    check_grid("simul");

    // Load during a generation is ignored
    run_gen(2, 3);
    check_grid("ldcalc");

    // Randomised loads and generations
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(1, 4)) do_load($urandom_range(0, 7), 8'($urandom));
      run_gen($urandom_range(0, 2), $urandom_range(1, 6));
      check_grid($sformatf("rnd%0d", it));
    end

    // Reset during a generation
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("midrst.busyA", 32'(busy_a), 32'd0);
    check_val("midrst.busyB", 32'(busy_b), 32'd0);
    check_val("midrst.doneB", 32'(done_b), 32'd0);
    check_val("midrst.rdA", 32'(rd_a), 32'd0);
    check_val("midrst.rdB", 32'(rd_b), 32'd0);
    check_status("midrst");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_grid("midrst");
    run_gen(0, 0);
    check_val("empty.ext", 32'(ext_b), 32'd1);
    check_val("empty.stable", 32'(stab_b), 32'd1);
    check_val("empty.gen", 32'(gen_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
Parametrised Game-of-Life array engine: holds a COLS x ROWS cell grid and advances it one generation per accepted step request. Rules are configurable through birth/survive masks; the boundary is selectable as toroidal or dead-edge. One row is evaluated per clock into a shadow buffer, then committed atomically. The engine sits between the step-tick divider and the display/readout logic, and replaces the per-cell automaton array.

Parameters:
COLS, 8, grid width in cells (>=3)
ROWS, 8, grid height in cells (>=3)
WRAP, 1, 1 = toroidal edges, 0 = cells outside the grid count as dead
BIRTH_MASK, 9'b000001000, bit n set = dead cell with n live neighbours becomes alive
SURVIVE_MASK, 9'b000001100, bit n set = live cell with n live neighbours stays alive
GEN_W, 16, generation counter width

Ports:
qzt_clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
step  in  1  request one generation; sampled each cycle
load_en  in  1  write load_data into grid row load_row (IDLE only)
load_row  in  clog2(ROWS)  row index for load and readout
load_data  in  COLS  row data; bit c = column c, 1 = alive
rd_data  out  COLS  registered copy of committed row load_row, 1-cycle latency
busy  out  1  high while a generation is being computed
done  out  1  one-cycle pulse after commit
gen_count  out  GEN_W  number of committed generations; wraps modulo 2^GEN_W
extinct  out  1  committed grid is all dead
stable  out  1  last commit produced a grid identical to its predecessor
overrun  out  1  sticky: step arrived while busy

Behaviour:
- Reset (async assert, sync-released internally): grid, shadow, rd_data, gen_count = 0; busy, done, stable, overrun = 0; extinct = 1; FSM = IDLE.
- FSM states: IDLE, CALC, COMMIT.
- IDLE: if load_en, write load_data to grid[load_row] and clear overrun. Else, if step, enter CALC with row index r = 0. load_en takes priority over a simultaneous step; that step is dropped and does not set overrun.
- CALC: each cycle compute shadow[r] from committed grid rows r-1, r, r+1. For each cell, n = sum of the 8 neighbours, 4-bit unsigned, 0..8. Next state = SURVIVE_MASK[n] if the cell is alive, else BIRTH_MASK[n]. Edges: WRAP=1 takes indices modulo COLS/ROWS; WRAP=0 supplies 0 for any out-of-range neighbour. Enter COMMIT after r = ROWS-1.
- COMMIT: grid <= shadow; gen_count += 1; stable <= (shadow == old grid); extinct <= (shadow == 0); done = 1 for exactly this cycle's registered output; return to IDLE.
- busy is high in CALC and COMMIT. Step-to-done latency is ROWS+1 cycles. The next step is accepted in the cycle after done.
- step while busy: ignored, overrun <= 1. load_en while busy: ignored, grid unchanged.
- Grid never changes during CALC; all neighbour reads come from the pre-step generation.
- rd_data <= grid[load_row] every cycle. An out-of-range load_row reads as 0, and a load to it is ignored.
- Reset asserted mid-CALC aborts immediately; the partial shadow is discarded and the grid is cleared.

Test Plan:
- Blinker, 5x5, WRAP=0: load row2 = 5'b01110, step -> done after ROWS+1 = 6 cycles; column 2 alive in rows1-3, gen_count = 1. Second step -> original pattern restored, gen_count = 2, stable = 0.
- Glider, 8x8, WRAP=1: load glider at top-left, 32 steps -> grid identical to the loaded pattern, gen_count = 32, extinct = 0.
- Block (2x2) still life: one step -> grid unchanged, stable = 1. Single isolated cell: one step -> extinct = 1.
- Overrun: step; then step again 3 cycles later while busy -> only one generation (gen_count + 1), overrun = 1. load_en in IDLE -> overrun = 0.
- Simultaneous load_en and step in IDLE -> row written, no CALC (busy stays 0), overrun = 0. load_en during CALC -> grid row unchanged after commit.
- Reset mid-CALC (rst_n low at r = 3): all outputs at reset values immediately. After release, step on the empty grid -> extinct = 1, stable = 1, gen_count = 1.
